// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Default geometry for the synchronous FIFO and a depth helper.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_mem
//  Purpose  : DEPTH x DATA_W dual-port register file, registered read port.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int c_DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // The array itself is never reset; only the output register is.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : fifo_mem
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO: pointer, occupancy and flag control around
//             the fifo_mem register file, with overflow/underflow pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [DATA_W-1:0] DIN,
  input  logic              RD_EN,
  output logic [DATA_W-1:0] DOUT,
  output logic              FULL,
  output logic              EMPTY,
  output logic [ADDR_W:0]   COUNT,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
);

  localparam logic [ADDR_W:0] c_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] r_wptr;
  logic [ADDR_W:0] r_rptr;
  logic [ADDR_W:0] r_count;
  logic            r_overflow;
  logic            r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // The pointer MSB is a lap bit: equal low bits mean full or empty, the lap
  // bit tells which.
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                    (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
  assign w_wr_acc = WR_EN && !w_full;
  assign w_rd_acc = RD_EN && !w_empty;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + c_ONE;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + c_ONE;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase
      r_overflow  <= WR_EN && w_full;
      r_underflow <= RD_EN && w_empty;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (CLK),
    .rst     (RST),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr[ADDR_W-1:0]),
    .i_wdata (DIN),
    .i_re    (w_rd_acc),
    .i_raddr (r_rptr[ADDR_W-1:0]),
    .o_rdata (DOUT)
  );

  assign FULL      = w_full;
  assign EMPTY     = w_empty;
  assign COUNT     = r_count;
  assign OVERFLOW  = r_overflow;
  assign UNDERFLOW = r_underflow;

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo
//  Purpose  : Scoreboard bench for sync_fifo against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

  localparam int c_DEPTH = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WR_EN = 1'b0;
  logic       RD_EN = 1'b0;
  logic [7:0] DIN = '0;
  logic [7:0] DOUT;
  logic       FULL, EMPTY, OVERFLOW, UNDERFLOW;
  logic [3:0] COUNT;

  typedef struct {
    logic [7:0] dout;
    int         count;
    bit         full;
    bit         empty;
    bit         ov;
    bit         un;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_q[$];
  logic [7:0] model_dout = '0;
  int         checks = 0;
  int         errors = 0;

  sync_fifo #(.DATA_W(8), .ADDR_W(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .WR_EN     (WR_EN),
    .DIN       (DIN),
    .RD_EN     (RD_EN),
    .DOUT      (DOUT),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .COUNT     (COUNT),
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t model_state(input bit ov, input bit un);
    exp_t e;
    e.dout  = model_dout;
    e.count = model_q.size();
    e.full  = (model_q.size() == c_DEPTH);
    e.empty = (model_q.size() == 0);
    e.ov    = ov;
    e.un    = un;
    return e;
  endfunction

  // One clock of stimulus; the model outcome for the following edge is queued.
  task automatic step(input bit wr, input bit rd, input logic [7:0] d);
    bit ov, un, acc_w, acc_r;
    @(negedge CLK);
    WR_EN = wr;
    RD_EN = rd;
    DIN   = d;
    ov    = wr && (model_q.size() == c_DEPTH);
    un    = rd && (model_q.size() == 0);
    acc_w = wr && !ov;
    acc_r = rd && !un;
    if (acc_r) model_dout = model_q.pop_front();
    if (acc_w) model_q.push_back(d);
    sb.push_back(model_state(ov, un));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"}, int'(COUNT), 0);
    chk({tag, "_empty"}, int'(EMPTY), 1);
    chk({tag, "_full"},  int'(FULL),  0);
    chk({tag, "_dout"},  int'(DOUT),  0);
    chk({tag, "_ovf"},   int'(OVERFLOW),  0);
    chk({tag, "_unf"},   int'(UNDERFLOW), 0);
  endtask

  // Monitor: compares every queued expectation against the DUT after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("dout",      int'(DOUT),      int'(e.dout));
        chk("count",     int'(COUNT),     e.count);
        chk("full",      int'(FULL),      int'(e.full));
        chk("empty",     int'(EMPTY),     int'(e.empty));
        chk("overflow",  int'(OVERFLOW),  int'(e.ov));
        chk("underflow", int'(UNDERFLOW), int'(e.un));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check_reset_state("init_reset");
    @(negedge CLK);
    RST = 1'b0;

    // Fill, then two overflowing writes of 0xAA.
    for (int i = 0; i < 8; i++) step(1, 0, 8'h11 + 8'(i));
    step(1, 0, 8'hAA);
    step(1, 0, 8'hAA);
    // Drain in order.
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00);
    step(0, 0, 8'h00);

    // Simultaneous access while empty, then read the accepted word.
    step(1, 1, 8'h5C);
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);

    // Simultaneous access while full.
    for (int i = 0; i < 8; i++) step(1, 0, 8'h11 + 8'(i));
    step(1, 1, 8'h99);
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00);

    // Pointer wrap: stream 20 words holding occupancy low.
    step(1, 0, 8'h00);
    for (int i = 1; i < 20; i++) step(1, 1, 8'(i));
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);

    // Randomised traffic with a bias that revisits full and empty.
    for (int i = 0; i < 400; i++) begin
      bit wr, rd;
      if ((i / 50) % 2 == 0) begin
        wr = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 3) == 0);
      end else begin
        wr = ($urandom_range(0, 3) == 0);
        rd = ($urandom_range(0, 3) != 0);
      end
      step(wr, rd, 8'($urandom));
    end

    // Mid-run asynchronous reset with five words held.
    while (model_q.size() > 0) step(0, 1, 8'h00);
    for (int i = 0; i < 5; i++) step(1, 0, 8'hE0 + 8'(i));
    @(negedge CLK);
    WR_EN = 1'b0;
    RD_EN = 1'b0;
    sb.push_back(model_state(0, 0));
    @(posedge CLK);
    #3;
    chk("pre_reset_count", int'(COUNT), 5);
    RST = 1'b1;
    #1;
    check_reset_state("async_reset");
    model_q.delete();
    model_dout = '0;
    sb.push_back(model_state(0, 0));
    @(negedge CLK);
    RST = 1'b0;
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);
    step(1, 0, 8'h3D);
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);

    repeat (2) @(posedge CLK);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sync_fifo
`default_nettype wire
